// File: rtl/bcd_counter_4d.sv
// Four-digit packed-BCD up/down counter stepped by a synchronized 1 Hz input,
// with validated parallel load. Reset is synchronous, active-low.
module bcd_counter_4d #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic        clk_1Hz,
  input  logic        en,
  input  logic        up_dn,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] bcd_out,
  output logic        tick,
  output logic        tc,
  output logic        load_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   synced;
  logic                   sync_d;
  logic                   armed;
  logic                   step;
  logic                   load_ok;
  logic [15:0]            next_cnt;
  logic                   wrap;

  assign synced = sync_q[SYNC_STAGES-1];
  assign step   = armed & synced & ~sync_d;

  always_comb begin
    load_ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    next_cnt = bcd_out;
    carry    = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      digit = bcd_out[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (digit == 4'd9) begin
            next_cnt[4*i +: 4] = 4'd0;
          end else begin
            next_cnt[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            next_cnt[4*i +: 4] = 4'd9;
          end else begin
            next_cnt[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap = carry;
  end

  // fill_q tracks how far real input has propagated through the cleared chain, so
  // arming waits for a genuine low sample rather than the reset zeros.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      sync_q   <= '0;
      fill_q   <= '0;
      sync_d   <= 1'b0;
      armed    <= 1'b0;
      bcd_out  <= '0;
      tick     <= 1'b0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_1Hz};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sync_d   <= synced;
      tick     <= 1'b0;
      tc       <= 1'b0;
      load_err <= 1'b0;
      if (fill_q[SYNC_STAGES-1] && !synced) armed <= 1'b1;
      if (load) begin
        if (load_ok) bcd_out  <= load_val;
        else         load_err <= 1'b1;
      end else if (step && en) begin
        bcd_out <= next_cnt;
        tick    <= 1'b1;
        tc      <= wrap;
      end
    end
  end

endmodule

// File: doc/bcd_counter_4d.md
BCD_COUNTER_4D -- requirements
Module: bcd_counter_4d

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on clk_1Hz (legal 2..4).
REQ-002 SHALL have port clk_50MHz, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, synchronous active-low reset, sampled on the clk_50MHz rising edge.
REQ-004 SHALL have port clk_1Hz, input, 1, free-running 1 Hz square wave from the 1 Hz generator; treated as asynchronous data.
REQ-005 SHALL have port en, input, 1, count enable; 1 = act on 1 Hz edges.
REQ-006 SHALL have port up_dn, input, 1, direction; 1 = increment, 0 = decrement.
REQ-007 SHALL have port load, input, 1, one-cycle synchronous load request.
REQ-008 SHALL have port load_val, input, 16, four packed BCD digits, [15:12] = thousands.
REQ-009 SHALL have port bcd_out, output, 16, current count, four packed BCD digits, registered.
REQ-010 SHALL have port tick, output, 1, one-cycle pulse in the cycle bcd_out shows a count step.
REQ-011 SHALL have port tc, output, 1, one-cycle pulse coincident with tick when the step wrapped.
REQ-012 SHALL have port load_err, output, 1, one-cycle pulse when a load was rejected.

Function
REQ-013 SHALL pass clk_1Hz through a SYNC_STAGES-deep flop chain; only the last stage is used.
REQ-014 SHALL form step = rising edge of the synchronized signal, gated by an armed flag.
REQ-015 SHALL set armed the first cycle the synchronized signal is sampled 0; armed stays 1 until reset, so a clk_1Hz already high at reset release yields no step.
REQ-016 SHALL update bcd_out at the (SYNC_STAGES+1)th clk_50MHz rising edge after clk_1Hz rises, given setup is met; 3 edges at default.
REQ-017 SHALL on step with en=1, up_dn=1: increment the count as four cascaded decimal digits, each 9 -> 0 with carry into the next digit.
REQ-018 SHALL on step with en=1, up_dn=0: decrement, each digit 0 -> 9 with borrow from the next digit.
REQ-019 SHALL wrap 9999 -> 0000 (up) and 0000 -> 9999 (down); tc=1 only on these two transitions.
REQ-020 SHALL ignore step when en=0: count held, tick=0, tc=0; the edge is consumed, not deferred.
REQ-021 SHALL on load=1 with every load_val digit <= 9: bcd_out <= load_val at the next edge; tick=0, tc=0.
REQ-022 SHALL on load=1 with any load_val digit > 9: hold bcd_out and pulse load_err for one cycle.
REQ-023 SHALL give load priority over step in the same cycle; that step is dropped, with no tick and no tc.
REQ-024 SHALL accept load regardless of en.
REQ-025 SHALL sample up_dn in the step cycle only; changing it between steps has no other effect.
REQ-026 SHALL keep every bcd_out nibble in 0..9 at all times after reset.
REQ-027 SHALL register tick, tc and load_err; none are asserted for more than one consecutive cycle per event.

Reset
REQ-028 SHALL, while reset_n=0 at a clock edge, drive bcd_out=16'h0000, tick=0, tc=0, load_err=0, and clear the synchronizer chain and armed.
REQ-029 SHALL take priority over load and step; reset asserted mid-count discards any pending edge.
REQ-030 SHALL NOT produce a step within SYNC_STAGES+1 cycles after reset release.

Verification
REQ-031 Reset, then en=1, up_dn=1, 12 clk_1Hz rising edges -> bcd_out 0000 -> 0012; one tick per edge, 3 cycles after each edge.
REQ-032 Load 0x9998 with en=1, up_dn=1, then 2 edges -> 9999, then 0000 with tc=1 on the 0000 cycle only; load 0x0001 with up_dn=0, then 2 edges -> 0000, then 9999 with tc=1.
REQ-033 Load 0x0099, then 1 up edge -> 0x0100 (digit carry); 1 down edge -> 0x0099 (borrow).
REQ-034 Load 0x12A4 -> bcd_out unchanged, load_err pulses 1 cycle; load asserted in the step cycle -> bcd_out = load_val, no tick.
REQ-035 en=0 across 3 edges -> bcd_out constant, tick=0; clk_1Hz high at reset release -> no step until the next genuine rising edge.
